async_fifo_gray: RTL and testbench
==================================

Name: async_fifo_gray

Overview:
Dual-clock FIFO, next generation of the team's async FIFO. Pointers cross domains as Gray code through multi-stage synchronizers, so full/empty are generated safely in their own clock domains. Adds programmable almost-full/almost-empty thresholds, per-side fill counts, and overflow/underflow error pulses. Sits between a producer on wr_clk and a consumer on rd_clk, e.g. a sample stream crossing into a processing clock.

Parameters:
DATA_WIDTH, 8, data word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16); legal range 2..12
SYNC_STAGES, 2, flip-flops per Gray pointer synchronizer; legal range 2..4
AFULL_THRESH, 12, almost_full asserted when wr_count >= AFULL_THRESH; legal range 1..DEPTH-1
AEMPTY_THRESH, 4, almost_empty asserted when rd_count <= AEMPTY_THRESH; legal range 1..DEPTH-1

Ports:
wr_clk  in  1  write-domain clock
rd_clk  in  1  read-domain clock
rst  in  1  reset, asynchronous, active-high; clears both domains
wr_en  in  1  write request (wr_clk)
din  in  DATA_WIDTH  write data
full  out  1  FIFO full (wr_clk, registered)
almost_full  out  1  wr_count >= AFULL_THRESH (wr_clk, registered)
wr_count  out  ADDR_WIDTH+1  conservative fill level seen from write side
overflow  out  1  one-cycle pulse: wr_en while full (wr_clk)
rd_en  in  1  read request (rd_clk)
dout  out  DATA_WIDTH  read data, registered
empty  out  1  FIFO empty (rd_clk, registered)
almost_empty  out  1  rd_count <= AEMPTY_THRESH (rd_clk, registered)
rd_count  out  ADDR_WIDTH+1  conservative fill level seen from read side
underflow  out  1  one-cycle pulse: rd_en while empty (rd_clk)

Behaviour:
- Reset: rst asserts asynchronously into every flop of both domains. Pointers, synchronizer chains, dout, wr_count, rd_count, overflow and underflow clear to 0. full=0, almost_full=0, empty=1, almost_empty=1. Memory contents are not reset.
- rst deassertion: must be held for at least SYNC_STAGES+2 cycles of the slower clock. Reset mid-operation discards all contents; no read returns pre-reset data.
- Pointers: binary wbin/rbin, ADDR_WIDTH+1 bits, wrap modulo 2*DEPTH. Gray copies wgray/rgray are registered as bin ^ (bin>>1). Only the Gray registers cross domains, each through SYNC_STAGES flops.
- Write: when wr_en && !full, mem[wbin[ADDR_WIDTH-1:0]] <= din and wbin increments. When wr_en && full, there is no write and no pointer change, and overflow=1 for the next cycle.
- Read: when rd_en && !empty, dout <= mem[rbin[ADDR_WIDTH-1:0]] with 1 rd_clk latency and rbin increments. Otherwise dout holds. When rd_en && empty, underflow=1 for the next cycle.
- full: registered. Set when next wgray equals the synchronized rgray with its two MSBs inverted and all other bits equal.
- empty: registered. Set when next rgray equals the synchronized wgray.
- wr_count = wbin_next - gray2bin(rgray_sync). rd_count = gray2bin(wgray_sync) - rbin_next. Both are registered, ADDR_WIDTH+1 bits, and range 0..DEPTH.
- Pessimism: counts and flags are conservative. full/almost_full may remain asserted, and empty/almost_empty may remain asserted, for up to SYNC_STAGES+1 cycles of the observing clock after the other side frees or fills space. The FIFO never overwrites unread data or reads stale data.
- Latency: a write reaches the read side (empty falls) within SYNC_STAGES+2 rd_clk edges. A read frees space (full falls) within SYNC_STAGES+2 wr_clk edges.
- Simultaneous write and read in unrelated clocks is always legal. A write on the cycle full asserts is blocked; a read on the cycle empty asserts is blocked.
- Wrap-around: pointer MSB toggles every DEPTH operations. Ordering and data stay exact across unlimited wraps.

Decomposition:
- Package async_fifo_pkg: functions bin2gray and gray2bin, parameterised by width; legal-range checks for the parameters as elaboration assertions.
- Sub-module cdc_sync_bus: SYNC_STAGES-deep, WIDTH-wide synchronizer with async reset. Instantiated twice, wgray->rd_clk and rgray->wr_clk.

Test Plan:
- Reset/idle: assert rst for 5 cycles with both clocks running -> empty=1, almost_empty=1, full=0, almost_full=0, wr_count=0, rd_count=0, dout=0.
- Fill/drain: wr_clk 100 MHz, rd_clk 37 MHz, default parameters. Write 0x00..0x0F -> full=1 after the 16th write and almost_full=1 once wr_count>=12. A 17th write (0xAA) pulses overflow and is dropped. Read 16 words -> 0x00..0x0F in order, empty=1.
- Underflow: rd_en on empty FIFO -> underflow pulse of exactly 1 rd_clk, dout unchanged, rd_count stays 0.
- Wrap: 1000 random words with random wr_en/rd_en at clock ratios 3:1, 1:3 and 1:1 with phase offset -> scoreboard exact match, no overflow/underflow, counts never exceed 16.
- Latency: single write of 0x5A into empty FIFO with SYNC_STAGES=3 -> empty falls within 5 rd_clk edges, and reading returns 0x5A one cycle after rd_en.
- Reset mid-operation: rst with 9 words stored -> after release, empty=1 and wr_count=0. The next write 0x33 is the first word read back.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared helpers for the Gray-pointer async FIFO.
//   bin2gray / gray2bin : pointer code conversion. Operands are zero-extended
//                         to PTR_MAX_W bits, so the functions serve any pointer
//                         width up to PTR_MAX_W; callers truncate the result.
//   params_legal        : constant function used for elaboration-time checks.
package async_fifo_pkg;

    // Widest pointer needed: ADDR_WIDTH up to 12, plus the wrap bit.
    localparam int PTR_MAX_W = 13;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of its Gray bit and every Gray bit above it.
    function automatic ptr_t gray2bin(ptr_t g);
        ptr_t b;
        b = g;
        for (int unsigned i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic bit params_legal(int aw, int ss, int af, int ae);
        int depth;
        depth = 1 << aw;
        return (aw >= 2) && (aw <= 12) && (ss >= 2) && (ss <= 4) &&
               (af >= 1) && (af <= depth - 1) &&
               (ae >= 1) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/async_fifo_gray_if.sv
// Producer/consumer handshake bundle of async_fifo_gray.
//   write side (wr_clk): wr_en, din -> full, almost_full, wr_count, overflow
//   read side  (rd_clk): rd_en      -> dout, empty, almost_empty, rd_count, underflow
//   master : the producer/consumer environment
//   slave  : the FIFO
interface async_fifo_gray_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  overflow;

    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   rd_count;
    logic                  underflow;

    modport master (
        output wr_en, din, rd_en,
        input  full, almost_full, wr_count, overflow,
        input  dout, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, almost_full, wr_count, overflow,
        output dout, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/async_fifo_gray_sync.sv
// cdc_sync_bus: STAGES-deep, WIDTH-wide flop chain for a Gray-coded bus
// entering the clk domain. Only one bit of the input changes at a time, so
// each synchronized word is either the old or the new pointer value.
//   clk, rst : destination clock, asynchronous active-high reset
//   d        : bus from the source domain
//   q        : synchronized bus
module cdc_sync_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/async_fifo_gray.sv
// async_fifo_gray: dual-clock FIFO with Gray-coded pointer crossing.
//   wr_clk, rd_clk : write / read domain clocks
//   rst            : asynchronous active-high reset, clears both domains
//   bus (slave)    : wr_en/din/full/almost_full/wr_count/overflow on wr_clk,
//                    rd_en/dout/empty/almost_empty/rd_count/underflow on rd_clk
// Flags and counts are computed from the next local pointer and the
// synchronized remote pointer, so they are exact locally and pessimistic
// with respect to the far side.
module async_fifo_gray
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input logic              wr_clk,
    input logic              rd_clk,
    input logic              rst,
    async_fifo_gray_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    if (!params_legal(ADDR_WIDTH, SYNC_STAGES, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
        $error("async_fifo_gray: parameter out of legal range");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wbin, wgray, wbin_next, wgray_next;
    logic [PW-1:0] rgray_sync, rbin_sync, wr_count_next;
    logic          wr_fire, full_next;

    always_comb begin
        wr_fire       = bus.wr_en && !bus.full;
        wbin_next     = wbin + {{ADDR_WIDTH{1'b0}}, wr_fire};
        wgray_next    = PW'(bin2gray(ptr_t'(wbin_next)));
        rbin_sync     = PW'(gray2bin(ptr_t'(rgray_sync)));
        wr_count_next = wbin_next - rbin_sync;
        // Write pointer one full lap ahead: two MSBs differ, rest equal.
        full_next     = (wgray_next == {~rgray_sync[PW-1:PW-2], rgray_sync[PW-3:0]});
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wbin             <= '0;
            wgray            <= '0;
            bus.full         <= 1'b0;
            bus.almost_full  <= 1'b0;
            bus.wr_count     <= '0;
            bus.overflow     <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            wgray            <= wgray_next;
            bus.full         <= full_next;
            bus.almost_full  <= (wr_count_next >= PW'(AFULL_THRESH));
            bus.wr_count     <= wr_count_next;
            bus.overflow     <= bus.wr_en && bus.full;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_fire) begin
            mem[wbin[ADDR_WIDTH-1:0]] <= bus.din;
        end
    end

    // ---------------- read domain ----------------
    logic [PW-1:0] rbin, rgray, rbin_next, rgray_next;
    logic [PW-1:0] wgray_sync, wbin_sync, rd_count_next;
    logic          rd_fire, empty_next;

    always_comb begin
        rd_fire       = bus.rd_en && !bus.empty;
        rbin_next     = rbin + {{ADDR_WIDTH{1'b0}}, rd_fire};
        rgray_next    = PW'(bin2gray(ptr_t'(rbin_next)));
        wbin_sync     = PW'(gray2bin(ptr_t'(wgray_sync)));
        rd_count_next = wbin_sync - rbin_next;
        empty_next    = (rgray_next == wgray_sync);
    end

    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            rbin              <= '0;
            rgray             <= '0;
            bus.dout          <= '0;
            bus.empty         <= 1'b1;
            bus.almost_empty  <= 1'b1;
            bus.rd_count      <= '0;
            bus.underflow     <= 1'b0;
        end else begin
            rbin              <= rbin_next;
            rgray             <= rgray_next;
            if (rd_fire) begin
                bus.dout <= mem[rbin[ADDR_WIDTH-1:0]];
            end
            bus.empty         <= empty_next;
            bus.almost_empty  <= (rd_count_next <= PW'(AEMPTY_THRESH));
            bus.rd_count      <= rd_count_next;
            bus.underflow     <= bus.rd_en && bus.empty;
        end
    end

    // ---------------- pointer crossings ----------------
    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk (rd_clk),
        .rst (rst),
        .d   (wgray),
        .q   (wgray_sync)
    );

    cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk (wr_clk),
        .rst (rst),
        .d   (rgray),
        .q   (rgray_sync)
    );
endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray: reset, fill/drain, overflow,
// underflow, randomized wrap traffic at several clock ratios, first-word
// latency on a SYNC_STAGES=3 instance, and reset during operation.
`timescale 1ns/100ps
module tb_async_fifo_gray;

    logic wr_clk = 1'b0;
    logic rd_clk = 1'b0;
    logic rst    = 1'b1;

    realtime wr_half = 5.0;
    realtime rd_half = 13.5;
    realtime rd_skew = 0.0;

    always begin
        #(wr_half) wr_clk = ~wr_clk;
    end

    always begin
        #(rd_half + rd_skew) rd_clk = ~rd_clk;
        rd_skew = 0.0;
    end

    async_fifo_gray_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();
    async_fifo_gray_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus3 ();

    async_fifo_gray #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) u_dut (
        .wr_clk (wr_clk),
        .rd_clk (rd_clk),
        .rst    (rst),
        .bus    (bus)
    );

    async_fifo_gray #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(3),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) u_dut3 (
        .wr_clk (wr_clk),
        .rd_clk (rd_clk),
        .rst    (rst),
        .bus    (bus3)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr_cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic rd_cyc();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic run_phase(input string name, input realtime wh, input realtime rh,
                             input realtime skew, input int n);
        int  nw, nr;
        bit  ovf_seen, unf_seen, cnt_bad;
        nw = 0; nr = 0; ovf_seen = 0; unf_seen = 0; cnt_bad = 0;
        wr_half = wh;
        rd_half = rh;
        rd_skew = skew;
        fork
            begin
                logic [7:0] d;
                for (int cyc = 0; cyc < 5000 && nw < n; cyc++) begin
                    wr_cyc();
                    if (bus.overflow) ovf_seen = 1;
                    if (bus.wr_count > 5'd16) cnt_bad = 1;
                    bus.wr_en = 1'b0;
                    if (!bus.full && $urandom_range(0, 3) != 0) begin
                        d = 8'($urandom);
                        bus.din   = d;
                        bus.wr_en = 1'b1;
                        sb.push_back(d);
                        nw++;
                    end
                end
                wr_cyc();
                bus.wr_en = 1'b0;
            end
            begin
                logic [7:0] exp;
                bit         pend;
                pend = 0;
                exp  = '0;
                for (int cyc = 0; cyc < 5000 && nr < n; cyc++) begin
                    rd_cyc();
                    if (pend) begin
                        check({name, "_data"}, bus.dout, exp);
                        nr++;
                        pend = 0;
                    end
                    if (bus.underflow) unf_seen = 1;
                    if (bus.rd_count > 5'd16) cnt_bad = 1;
                    bus.rd_en = 1'b0;
                    if (nr < n && !bus.empty && sb.size() > 0 && $urandom_range(0, 3) != 0) begin
                        bus.rd_en = 1'b1;
                        exp  = sb.pop_front();
                        pend = 1;
                    end
                end
                bus.rd_en = 1'b0;
            end
        join
        check({name, "_written"}, nw, n);
        check({name, "_read"}, nr, n);
        check({name, "_no_overflow"}, ovf_seen, 0);
        check({name, "_no_underflow"}, unf_seen, 0);
        check({name, "_count_range"}, cnt_bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int found;
        bus.wr_en  = 1'b0; bus.din  = '0; bus.rd_en  = 1'b0;
        bus3.wr_en = 1'b0; bus3.din = '0; bus3.rd_en = 1'b0;

        // ---------------- reset / idle ----------------
        rst = 1'b1;
        repeat (6) rd_cyc();
        check("rst_empty",        bus.empty,        1);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_full",         bus.full,         0);
        check("rst_almost_full",  bus.almost_full,  0);
        check("rst_wr_count",     bus.wr_count,     0);
        check("rst_rd_count",     bus.rd_count,     0);
        check("rst_dout",         bus.dout,         0);
        check("rst_overflow",     bus.overflow,     0);
        check("rst_underflow",    bus.underflow,    0);
        rst = 1'b0;
        repeat (3) rd_cyc();
        check("idle_empty", bus.empty, 1);
        check("idle_full",  bus.full,  0);

        // ---------------- fill ----------------
        wr_cyc();
        for (int i = 0; i < 16; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = 8'(i);
            wr_cyc();
            check("fill_wr_count",    bus.wr_count,    i + 1);
            check("fill_almost_full", bus.almost_full, (i + 1 >= 12));
            check("fill_full",        bus.full,        (i == 15));
        end
        bus.din = 8'hAA;
        wr_cyc();
        bus.wr_en = 1'b0;
        check("ovf_pulse",    bus.overflow, 1);
        check("ovf_wr_count", bus.wr_count, 16);
        check("ovf_full",     bus.full,     1);
        wr_cyc();
        check("ovf_clear", bus.overflow, 0);

        repeat (5) rd_cyc();
        check("fill_rd_empty",        bus.empty,        0);
        check("fill_rd_count",        bus.rd_count,     16);
        check("fill_rd_almost_empty", bus.almost_empty, 0);

        // ---------------- drain ----------------
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            rd_cyc();
            check("drain_dout",         bus.dout,         i);
            check("drain_rd_count",     bus.rd_count,     15 - i);
            check("drain_almost_empty", bus.almost_empty, (15 - i <= 4));
        end
        bus.rd_en = 1'b0;
        check("drain_empty", bus.empty, 1);
        repeat (6) wr_cyc();
        check("drain_wr_count",    bus.wr_count,    0);
        check("drain_full",        bus.full,        0);
        check("drain_almost_full", bus.almost_full, 0);

        // ---------------- underflow ----------------
        rd_cyc();
        bus.rd_en = 1'b1;
        rd_cyc();
        bus.rd_en = 1'b0;
        check("unf_pulse",    bus.underflow, 1);
        check("unf_dout",     bus.dout,      8'h0F);
        check("unf_rd_count", bus.rd_count,  0);
        rd_cyc();
        check("unf_clear",      bus.underflow, 0);
        check("unf_dout_hold",  bus.dout,      8'h0F);

        // ---------------- wrap traffic ----------------
        run_phase("wrap_3to1", 5.0,  15.0, 0.0, 334);
        run_phase("wrap_1to3", 15.0, 5.0,  0.0, 333);
        run_phase("wrap_1to1", 5.0,  5.0,  2.5, 333);
        check("wrap_sb_empty", sb.size(), 0);

        // ---------------- first-word latency, SYNC_STAGES=3 ----------------
        wr_cyc();
        bus3.wr_en = 1'b1;
        bus3.din   = 8'h5A;
        wr_cyc();
        bus3.wr_en = 1'b0;
        found = 0;
        for (int k = 1; k <= 5; k++) begin
            rd_cyc();
            if (!bus3.empty) begin
                found = 1;
                break;
            end
        end
        check("lat_empty_fall", found, 1);
        check("lat_rd_count", bus3.rd_count, 1);
        bus3.rd_en = 1'b1;
        rd_cyc();
        bus3.rd_en = 1'b0;
        check("lat_dout",  bus3.dout,  8'h5A);
        check("lat_empty", bus3.empty, 1);

        // ---------------- reset mid-operation ----------------
        wr_cyc();
        for (int i = 0; i < 9; i++) begin
            bus.wr_en = 1'b1;
            bus.din   = 8'(8'h10 + i);
            wr_cyc();
        end
        bus.wr_en = 1'b0;
        repeat (5) rd_cyc();
        check("mid_rd_count_before", bus.rd_count, 9);
        rst = 1'b1;
        repeat (6) rd_cyc();
        check("mid_rst_empty",    bus.empty,    1);
        check("mid_rst_wr_count", bus.wr_count, 0);
        rst = 1'b0;
        repeat (3) rd_cyc();
        check("mid_post_empty",    bus.empty,    1);
        check("mid_post_wr_count", bus.wr_count, 0);
        check("mid_post_rd_count", bus.rd_count, 0);
        check("mid_post_full",     bus.full,     0);
        wr_cyc();
        bus.wr_en = 1'b1;
        bus.din   = 8'h33;
        wr_cyc();
        bus.wr_en = 1'b0;
        found = 0;
        for (int k = 0; k < 8; k++) begin
            rd_cyc();
            if (!bus.empty) begin
                found = 1;
                break;
            end
        end
        check("mid_word_arrives", found, 1);
        bus.rd_en = 1'b1;
        rd_cyc();
        bus.rd_en = 1'b0;
        check("mid_first_word", bus.dout,  8'h33);
        check("mid_empty_after", bus.empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
